// File: rtl/ac_motor_gate_monitor_if.sv
// Gate-pair bundle between the dead-time switch-delay stage (master) and
// anything that consumes the six gate lines (slave).
interface ac_motor_gate_monitor_if;
  logic s1_high;
  logic s1_low;
  logic s2_high;
  logic s2_low;
  logic s3_high;
  logic s3_low;

  modport master (
    output s1_high, s1_low, s2_high, s2_low, s3_high, s3_low
  );

  modport slave (
    input s1_high, s1_low, s2_high, s2_low, s3_high, s3_low
  );
endinterface

// File: rtl/ac_motor_gate_monitor.sv
// Safety monitor for three high/low gate pairs: reconstructs switch state,
// measures each dead band and latches shoot-through / short-dead-time faults.
module ac_motor_gate_monitor #(
  parameter int DW = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DW-1:0]          delay,
  input  logic                   clear_fault,
  ac_motor_gate_monitor_if.slave gates,
  output logic [2:0]             s_rec,
  output logic [2:0]             shoot_through,
  output logic [2:0]             dead_time_err,
  output logic                   fault,
  output logic                   dt_valid,
  output logic [1:0]             dt_phase,
  output logic [DW-1:0]          dt_value
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HIGH_ON = 3'd1;
  localparam logic [2:0] S_LOW_ON  = 3'd2;
  localparam logic [2:0] S_DEAD_H  = 3'd3;
  localparam logic [2:0] S_DEAD_L  = 3'd4;
  localparam logic [2:0] S_SHOOT   = 3'd5;

  localparam logic [1:0] G_OFF  = 2'b00;
  localparam logic [1:0] G_L    = 2'b01;
  localparam logic [1:0] G_H    = 2'b10;
  localparam logic [1:0] G_BOTH = 2'b11;

  localparam logic [DW-1:0] CNT_ONE = DW'(1);
  localparam logic [DW-1:0] CNT_MAX = '1;

  // Phase p occupies bits {2p+1, 2p} = {high, low}.
  logic [5:0]              g_pin;
  logic [5:0]              g_q;
  logic [2:0][2:0]         st;
  logic [2:0][2:0]         st_nx;
  logic [2:0][DW-1:0]      cnt;
  logic [2:0][DW-1:0]      cnt_nx;
  logic [2:0]              meas;
  logic [2:0][DW-1:0]      meas_val;
  logic [2:0]              shoot_set;
  logic [2:0]              err_set;
  logic [1:0]              sel_phase;
  logic [DW-1:0]           sel_value;

  assign g_pin = {gates.s3_high, gates.s3_low,
                  gates.s2_high, gates.s2_low,
                  gates.s1_high, gates.s1_low};

  assign fault = (|shoot_through) | (|dead_time_err);

  always_comb begin
    logic [1:0] gp;
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    st_nx     = st;
    cnt_nx    = cnt;
    meas      = '0;
    meas_val  = '0;
    shoot_set = '0;
    err_set   = '0;
    sel_phase = 2'd0;
    sel_value = '0;
    gp        = G_OFF;

    for (int p = 0; p < 3; p++) begin
      gp = g_q[2*p +: 2];
      case (st[p])
        S_IDLE: begin
          case (gp)
            G_H:     st_nx[p] = S_HIGH_ON;
            G_L:     st_nx[p] = S_LOW_ON;
            G_BOTH:  begin st_nx[p] = S_SHOOT; shoot_set[p] = 1'b1; end
            default: ;
          endcase
        end
        S_HIGH_ON: begin
          case (gp)
            G_OFF:   begin st_nx[p] = S_DEAD_H; cnt_nx[p] = CNT_ONE; end
            G_L:     begin st_nx[p] = S_LOW_ON; meas[p] = 1'b1; end
            G_BOTH:  begin st_nx[p] = S_SHOOT; shoot_set[p] = 1'b1; end
            default: ;
          endcase
        end
        S_LOW_ON: begin
          case (gp)
            G_OFF:   begin st_nx[p] = S_DEAD_L; cnt_nx[p] = CNT_ONE; end
            G_H:     begin st_nx[p] = S_HIGH_ON; meas[p] = 1'b1; end
            G_BOTH:  begin st_nx[p] = S_SHOOT; shoot_set[p] = 1'b1; end
            default: ;
          endcase
        end
        S_DEAD_H: begin
          case (gp)
            G_OFF:  cnt_nx[p] = (cnt[p] == CNT_MAX) ? CNT_MAX : cnt[p] + CNT_ONE;
            G_L:    begin st_nx[p] = S_LOW_ON; meas[p] = 1'b1; meas_val[p] = cnt[p]; end
            G_H:    st_nx[p] = S_HIGH_ON;  // glitch back to the same side
            G_BOTH: begin st_nx[p] = S_SHOOT; shoot_set[p] = 1'b1; end
          endcase
        end
        S_DEAD_L: begin
          case (gp)
            G_OFF:  cnt_nx[p] = (cnt[p] == CNT_MAX) ? CNT_MAX : cnt[p] + CNT_ONE;
            G_H:    begin st_nx[p] = S_HIGH_ON; meas[p] = 1'b1; meas_val[p] = cnt[p]; end
            G_L:    st_nx[p] = S_LOW_ON;
            G_BOTH: begin st_nx[p] = S_SHOOT; shoot_set[p] = 1'b1; end
          endcase
        end
        S_SHOOT: begin
          case (gp)
            G_H:     st_nx[p] = S_HIGH_ON;
            G_L:     st_nx[p] = S_LOW_ON;
            G_OFF:   st_nx[p] = S_IDLE;
            default: ;
          endcase
        end
        default: st_nx[p] = S_IDLE;
      endcase
      err_set[p] = meas[p] && (delay != '0) && (meas_val[p] < delay);
    end

    // Walk downward so the lowest-numbered measuring phase is reported.
    for (int p = 2; p >= 0; p--) begin
      if (meas[p]) begin
        sel_phase = 2'(p + 1);
        sel_value = meas_val[p];
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g_q           <= '0;
      st            <= {3{S_IDLE}};
      cnt           <= '0;
      s_rec         <= '0;
      shoot_through <= '0;
      dead_time_err <= '0;
      dt_valid      <= 1'b0;
      dt_phase      <= 2'd0;
      dt_value      <= '0;
    end else begin
      g_q <= g_pin;
      if (enable) begin
        st  <= st_nx;
        cnt <= cnt_nx;
        for (int p = 0; p < 3; p++) begin
          if (st_nx[p] == S_HIGH_ON)     s_rec[p] <= 1'b1;
          else if (st_nx[p] == S_LOW_ON) s_rec[p] <= 1'b0;
        end
        // A new fault in the same cycle as clear_fault survives the clear.
        shoot_through <= (clear_fault ? 3'b000 : shoot_through) | shoot_set;
        dead_time_err <= (clear_fault ? 3'b000 : dead_time_err) | err_set;
        dt_valid      <= |meas;
        if (|meas) begin
          dt_phase <= sel_phase;
          dt_value <= sel_value;
        end
      end else begin
        st       <= {3{S_IDLE}};
        cnt      <= '0;
        dt_valid <= 1'b0;
        if (clear_fault) begin
          shoot_through <= '0;
          dead_time_err <= '0;
        end
      end
    end
  end

endmodule

// File: doc/ac_motor_gate_monitor.md
# ac_motor_gate_monitor

Receiving end of the dead-time gate interface: samples the three high/low gate pairs produced by the switch-delay stage, reconstructs each phase's switch state, measures every dead band and raises sticky faults on shoot-through or dead time shorter than the programmed minimum. It sits between the gate-pair outputs and the power-stage driver as a safety monitor. It also serves as a self-checking sink in the motor-chain benches.

## Interface
- DW, 11, width of delay, counters and measurement output
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- enable  in  1  monitor enable; 0 = FSMs forced to IDLE, counters cleared, sticky flags held
- delay  in  DW  minimum required dead time in clk cycles; 0 disables the dead-time check
- clear_fault  in  1  synchronous clear of all sticky flags
- s1_high, s1_low, s2_high, s2_low, s3_high, s3_low  in  1 each  gate pairs, phase 1..3
- s_rec  out  3  reconstructed switch state per phase, bit0 = phase 1; 1 = high side on
- shoot_through  out  3  sticky per phase: both gates on observed
- dead_time_err  out  3  sticky per phase: dead band shorter than delay
- fault  out  1  OR of shoot_through and dead_time_err
- dt_valid  out  1  one-cycle pulse: dt_value/dt_phase updated
- dt_phase  out  2  phase of last measurement, 1..3 (0 after reset)
- dt_value  out  DW  last measured dead band length in cycles

## Operation
- Input stage: all six gates registered once (g_q); FSMs act only on g_q.
- Per-phase FSM, states IDLE, HIGH_ON, LOW_ON, DEAD_H (left HIGH_ON), DEAD_L (left LOW_ON), SHOOT. g_q decoded as H=10, L=01, OFF=00, BOTH=11.
- IDLE: H -> HIGH_ON, L -> LOW_ON, BOTH -> SHOOT, OFF -> stay. No measurement from IDLE.
- HIGH_ON: OFF -> DEAD_H, count <= 1; L -> LOW_ON with measurement value 0; BOTH -> SHOOT.
- LOW_ON: symmetric (OFF -> DEAD_L, H -> HIGH_ON with value 0).
- DEAD_H: OFF -> count += 1, saturating at 2^DW-1; L -> LOW_ON with measurement = count; H -> HIGH_ON, glitch return, no measurement, no error; BOTH -> SHOOT. DEAD_L symmetric.
- SHOOT: BOTH -> stay; H -> HIGH_ON, L -> LOW_ON, OFF -> IDLE; no measurement on exit.
- Measurement: sets dead_time_err[p] if delay != 0 and value < delay; value == delay passes.
- Entering SHOOT sets shoot_through[p].
- s_rec[p]: 1 in HIGH_ON, 0 in LOW_ON, holds in DEAD_x, SHOOT, IDLE; 0 after reset.
- Simultaneous measurements: dt_value/dt_phase report lowest-numbered phase only, others dropped from the report; error flags of all phases still evaluated.
- clear_fault and new flag set in the same cycle: set wins.
- enable = 0: FSMs -> IDLE, counts -> 0, s_rec held, sticky flags and dt_value held, dt_valid = 0.

## Timing
- Reset values: g_q 0, all FSMs IDLE, counts 0, s_rec 0, shoot_through 0, dead_time_err 0, fault 0, dt_valid 0, dt_phase 0, dt_value 0.
- Latency: gate change sampled at edge N -> FSM/s_rec/flags/dt_* updated at edge N+1. fault is combinational OR of registered flags, same cycle as flags.
- Dead band of k cycles at the pins (both gates low for k rising edges) -> dt_value = k.
- Reset asserted mid-dead-band: measurement discarded; after release, first ON state enters from IDLE without measurement.

## Test plan
- Phase 1 H for 10 cycles, OFF 4 cycles, L; delay=4 -> dt_valid pulse, dt_phase=1, dt_value=4, dead_time_err=000, s_rec[0] 1 -> 0 two edges after L applied.
- Same with OFF 3 cycles, delay=4 -> dt_value=3, dead_time_err=001, fault=1; clear_fault pulse -> 000, fault=0.
- Phase 2 H then direct L (no dead band), delay=4 -> dt_value=0, dead_time_err=010; delay=0 repeat after clear -> no error.
- Phase 3 both gates high 1 cycle -> shoot_through=100, s_rec[2] held; then OFF -> IDLE, next L gives no dt_valid.
- H, OFF 2 cycles, H again -> no dt_valid, no error, s_rec stays 1; phases 1 and 3 complete dead bands same cycle -> dt_phase=1 only, both errors evaluated.
- Reset asserted during 5-cycle dead band, enable=0 then 1 -> all outputs 0 immediately, no measurement from pre-reset band.
